// File: rtl/dac_spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_spi_pkg : shared state encoding and frame sizing for dac_spi_master
// Revision    : 1.0
// ----------------------------------------------------------------------------
package dac_spi_pkg;

  localparam int COMM_W = 4;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  function automatic int frame_bits(input int data_w);
    return COMM_W + ADDR_W + data_w;
  endfunction

  function automatic int cs_width(input int ncs);
    return (ncs > 1) ? $clog2(ncs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_master_clk_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_clk_div : half-period timebase, tick on the last clk cycle of each DIV
// Revision    : 1.0
// ----------------------------------------------------------------------------
module spi_clk_div #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_spi_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_spi_master : {comm,addr,data} command serialiser with MISO readback
// Revision       : 1.0
// ----------------------------------------------------------------------------
module dac_spi_master
  import dac_spi_pkg::*;
#(
  parameter int   DATA_W  = 16,
  parameter int   DIV     = 16,
  parameter int   GAP_CYC = 32,
  parameter int   NCS     = 1,
  parameter logic CPOL    = 1'b1,
  parameter logic CPHA    = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [COMM_W-1:0]               cmd_comm_i,
  input  logic [ADDR_W-1:0]               cmd_addr_i,
  input  logic [DATA_W-1:0]               cmd_data_i,
  input  logic [cs_width(NCS)-1:0]        cmd_cs_i,
  input  logic                            abort_i,
  output logic                            rd_valid_o,
  output logic [frame_bits(DATA_W)-1:0]   rd_data_o,
  output logic                            cmd_err_o,
  output logic                            busy_o,
  output logic                            spi_sclk_o,
  output logic [NCS-1:0]                  spi_sync_n_o,
  output logic                            spi_mosi_o,
  input  logic                            spi_miso_i
);

  localparam int FB = frame_bits(DATA_W);
  localparam int KW = $clog2(2 * FB);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(2 * FB - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [GW-1:0]   gap_q;
  logic [FB-1:0]   sh_q;
  logic [FB-1:0]   cap_q;
  logic [FB-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic            cmd_err_q;
  logic            sclk_q;
  logic [NCS-1:0]  sync_n_q;

  logic            w_tick;
  logic            w_clr;
  logic            w_active;
  logic            w_abort;
  logic            w_bad_cs;
  logic [NCS-1:0]  w_sel_n;

  assign w_active = (state_q == ST_LEAD) || (state_q == ST_SHIFT) || (state_q == ST_TRAIL);
  assign w_abort  = w_active && abort_i;
  assign w_bad_cs = 32'(cmd_cs_i) >= 32'(NCS);
  // Divider is held at zero outside the DIV-timed states, so every timed state starts at count 0.
  assign w_clr    = (state_q == ST_IDLE) || (state_q == ST_GAP) || w_abort;

  always_comb begin
    w_sel_n = '1;
    for (int i = 0; i < NCS; i++) begin
      w_sel_n[i] = (32'(cmd_cs_i) != 32'(i));
    end
  end

  spi_clk_div #(
    .DIV (DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (w_clr),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      gap_q      <= '0;
      sh_q       <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      sclk_q     <= CPOL;
      sync_n_q   <= '1;
    end else begin
      rd_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      if (w_abort) begin
        state_q  <= ST_GAP;
        gap_q    <= '0;
        sh_q     <= '0;
        sclk_q   <= CPOL;
        sync_n_q <= '1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (cmd_valid_i) begin
              if (w_bad_cs) begin
                cmd_err_q <= 1'b1;
              end else begin
                state_q  <= ST_LEAD;
                sh_q     <= {cmd_comm_i, cmd_addr_i, cmd_data_i};
                k_q      <= '0;
                sclk_q   <= CPOL;
                sync_n_q <= w_sel_n;
              end
            end
          end
          ST_LEAD: begin
            if (w_tick) begin
              state_q <= ST_SHIFT;
              sclk_q  <= CPOL ^ CPHA;
            end
          end
          ST_SHIFT: begin
            if (w_tick) begin
              // End of an even half-period: this edge is the sampling edge in every mode.
              if (!k_q[0]) begin
                cap_q <= {cap_q[FB-2:0], spi_miso_i};
              end
              if (k_q == K_LAST) begin
                state_q <= ST_TRAIL;
                sclk_q  <= CPOL;
              end else begin
                k_q    <= k_q + KW'(1);
                sclk_q <= CPOL ^ CPHA ^ ~k_q[0];
                if (k_q[0]) begin
                  sh_q <= sh_q << 1;
                end
              end
            end
          end
          ST_TRAIL: begin
            if (w_tick) begin
              state_q    <= ST_GAP;
              gap_q      <= '0;
              sh_q       <= '0;
              sync_n_q   <= '1;
              rd_valid_q <= 1'b1;
              rd_data_q  <= cap_q;
            end
          end
          ST_GAP: begin
            if (gap_q == G_LAST) begin
              state_q <= ST_IDLE;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign cmd_err_o    = cmd_err_q;
  assign spi_sclk_o   = sclk_q;
  assign spi_sync_n_o = sync_n_q;
  assign spi_mosi_o   = sh_q[FB-1];

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dac_spi_master : scoreboard bench for dac_spi_master in several configs
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_dac_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default configuration: DATA_W=16, DIV=16, GAP_CYC=32, NCS=1, CPOL=1, CPHA=0
  logic        v0 = 0, ab0 = 0, loop0 = 0;
  logic [3:0]  comm0 = 0, addr0 = 0;
  logic [15:0] data0 = 0;
  logic [0:0]  cs0 = 0;
  logic        miso0, rdy0, rdv0, err0, busy0, sclk0, mosi0;
  logic [23:0] rdd0;
  logic [0:0]  sync0;
  assign miso0 = loop0 ? mosi0 : 1'b0;

  dac_spi_master u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(v0), .cmd_ready_o(rdy0),
    .cmd_comm_i(comm0), .cmd_addr_i(addr0), .cmd_data_i(data0), .cmd_cs_i(cs0),
    .abort_i(ab0), .rd_valid_o(rdv0), .rd_data_o(rdd0), .cmd_err_o(err0),
    .busy_o(busy0), .spi_sclk_o(sclk0), .spi_sync_n_o(sync0), .spi_mosi_o(mosi0),
    .spi_miso_i(miso0)
  );

  // Three chip selects, faster divider, short gap
  logic        v3 = 0, ab3 = 0;
  logic [3:0]  comm3 = 0, addr3 = 0;
  logic [15:0] data3 = 0;
  logic [1:0]  cs3 = 0;
  logic        rdy3, rdv3, err3, busy3, sclk3, mosi3;
  logic [23:0] rdd3;
  logic [2:0]  sync3;

  dac_spi_master #(.DATA_W(16), .DIV(4), .GAP_CYC(8), .NCS(3), .CPOL(1'b1), .CPHA(1'b0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(v3), .cmd_ready_o(rdy3),
    .cmd_comm_i(comm3), .cmd_addr_i(addr3), .cmd_data_i(data3), .cmd_cs_i(cs3),
    .abort_i(ab3), .rd_valid_o(rdv3), .rd_data_o(rdd3), .cmd_err_o(err3),
    .busy_o(busy3), .spi_sclk_o(sclk3), .spi_sync_n_o(sync3), .spi_mosi_o(mosi3),
    .spi_miso_i(1'b0)
  );

  // Mode sweep pair sharing one command stream: A is CPOL0/CPHA1, B is CPOL0/CPHA0
  logic        mv = 0;
  logic [3:0]  mcomm = 0, maddr = 0;
  logic [7:0]  mdata = 0;
  logic [0:0]  mcs = 0;
  logic        rdyA, rdvA, errA, busyA, sclkA, mosiA;
  logic        rdyB, rdvB, errB, busyB, sclkB, mosiB;
  logic [15:0] rddA, rddB;
  logic [0:0]  syncA, syncB;

  dac_spi_master #(.DATA_W(8), .DIV(2), .GAP_CYC(4), .NCS(1), .CPOL(1'b0), .CPHA(1'b1)) u_dutA (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(mv), .cmd_ready_o(rdyA),
    .cmd_comm_i(mcomm), .cmd_addr_i(maddr), .cmd_data_i(mdata), .cmd_cs_i(mcs),
    .abort_i(1'b0), .rd_valid_o(rdvA), .rd_data_o(rddA), .cmd_err_o(errA),
    .busy_o(busyA), .spi_sclk_o(sclkA), .spi_sync_n_o(syncA), .spi_mosi_o(mosiA),
    .spi_miso_i(mosiA)
  );

  dac_spi_master #(.DATA_W(8), .DIV(2), .GAP_CYC(4), .NCS(1), .CPOL(1'b0), .CPHA(1'b0)) u_dutB (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(mv), .cmd_ready_o(rdyB),
    .cmd_comm_i(mcomm), .cmd_addr_i(maddr), .cmd_data_i(mdata), .cmd_cs_i(mcs),
    .abort_i(1'b0), .rd_valid_o(rdvB), .rd_data_o(rddB), .cmd_err_o(errB),
    .busy_o(busyB), .spi_sclk_o(sclkB), .spi_sync_n_o(syncB), .spi_mosi_o(mosiB),
    .spi_miso_i(mosiB)
  );

  // Scoreboard for u_dut0: bits seen at falling sclk edges and readback words
  logic [23:0] exp_frame0[$];
  logic [23:0] exp_rd0[$];
  logic [23:0] mon_bits = 0;
  logic [23:0] mon_exp;
  int          mon_n = 0;
  logic        prev_sclk0 = 1'b1;
  logic        prev_sync0 = 1'b1;

  always @(negedge clk) begin
    if (sync0 === 1'b0) begin
      if (prev_sclk0 === 1'b1 && sclk0 === 1'b0) begin
        mon_bits = {mon_bits[22:0], mosi0};
        mon_n++;
      end
    end else if (prev_sync0 === 1'b0) begin
      if (mon_n == 24) begin
        chk_cnt++;
        if (exp_frame0.size() == 0) begin
          $display("FAIL frame0_unexpected got=%h required=none", mon_bits);
        end else begin
          mon_exp = exp_frame0.pop_front();
          if (mon_bits !== mon_exp) $display("FAIL frame0_bits got=%h required=%h", mon_bits, mon_exp);
          else pass_cnt++;
        end
      end
      mon_n    = 0;
      mon_bits = 0;
    end
    if (rdv0 === 1'b1) begin
      chk_cnt++;
      if (exp_rd0.size() == 0) begin
        $display("FAIL rd0_unexpected got=%h required=none", rdd0);
      end else begin
        mon_exp = exp_rd0.pop_front();
        if (rdd0 !== mon_exp) $display("FAIL rd0_data got=%h required=%h", rdd0, mon_exp);
        else pass_cnt++;
      end
    end
    prev_sclk0 = sclk0;
    prev_sync0 = sync0;
  end

  // Offers a command to u_dut0 and returns at the negedge after acceptance.
  task automatic send0(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d, output int acc);
    int n = 0;
    comm0 = c; addr0 = a; data0 = d; cs0 = 1'b0; v0 = 1'b1;
    while (rdy0 !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    @(negedge clk);
    v0 = 1'b0; comm0 = 4'h0; addr0 = 4'h0; data0 = 16'hFFFF;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({rdy0, busy0, sclk0, sync0, mosi0, rdv0, err0, rdd0} !== {7'b1011000, 24'h0})
      $display("FAIL reset_dut0 got=%b required=%b", {rdy0, busy0, sclk0, sync0, mosi0, rdv0, err0, rdd0}, {7'b1011000, 24'h0});
    else pass_cnt++;
    chk_cnt++;
    if ({rdy3, busy3, sclk3, sync3, mosi3, rdv3, err3, rdd3} !== {9'b101111000, 24'h0})
      $display("FAIL reset_dut3 got=%b required=%b", {rdy3, busy3, sclk3, sync3, mosi3, rdv3, err3, rdd3}, {9'b101111000, 24'h0});
    else pass_cnt++;
    chk_cnt++;
    if ({rdyA, busyA, sclkA, syncA, mosiA, rdvA, errA, rddA, rdyB, busyB, sclkB, syncB, mosiB, rdvB, errB, rddB}
        !== {7'b1001000, 16'h0, 7'b1001000, 16'h0})
      $display("FAIL reset_modes got=%b required=%b",
               {rdyA, busyA, sclkA, syncA, mosiA, rdvA, errA, rddA, rdyB, busyB, sclkB, syncB, mosiB, rdvB, errB, rddB},
               {7'b1001000, 16'h0, 7'b1001000, 16'h0});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({rdy0, busy0, sync0} !== 3'b101) $display("FAIL idle_after_reset got=%b required=101", {rdy0, busy0, sync0});
    else pass_cnt++;
  endtask

  task automatic test_basic_write();
    int acc, fall_at = -1, rise_at = -1, low_cnt = 0;
    loop0 = 1'b0;
    exp_frame0.push_back(24'h31A5C3);
    exp_rd0.push_back(24'h000000);
    send0(4'h3, 4'h1, 16'hA5C3, acc);
    for (int n = 0; n < 2000; n++) begin
      if (sync0 === 1'b0) begin
        low_cnt++;
        if (fall_at < 0) fall_at = cyc;
      end
      if (rdy0 === 1'b1) begin
        rise_at = cyc;
        break;
      end
      @(negedge clk);
    end
    chk_cnt++;
    if (fall_at - acc != 1) $display("FAIL basic_sync_fall got=%0d required=1", fall_at - acc);
    else pass_cnt++;
    chk_cnt++;
    if (low_cnt != 800) $display("FAIL basic_sync_low got=%0d required=800", low_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (rise_at - acc != 833) $display("FAIL basic_ready_latency got=%0d required=833", rise_at - acc);
    else pass_cnt++;
  endtask

  task automatic test_readback();
    int acc, rd_cnt = 0, n = 0;
    loop0 = 1'b1;
    exp_frame0.push_back(24'hF25A0F);
    exp_rd0.push_back(24'hF25A0F);
    send0(4'hF, 4'h2, 16'h5A0F, acc);
    while (rdy0 !== 1'b1 && n < 2000) begin
      if (rdv0 === 1'b1) rd_cnt++;
      @(negedge clk);
      n++;
    end
    repeat (4) begin
      if (rdv0 === 1'b1) rd_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if (rd_cnt != 1) $display("FAIL readback_pulses got=%0d required=1", rd_cnt);
    else pass_cnt++;
    loop0 = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int acc, n = 0;
    send0(4'h1, 4'h2, 16'h1234, acc);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({rdy0, busy0, sclk0, sync0, mosi0, rdv0, err0, rdd0} !== {7'b1011000, 24'h0})
      $display("FAIL reset_mid_outputs got=%b required=%b", {rdy0, busy0, sclk0, sync0, mosi0, rdv0, err0, rdd0}, {7'b1011000, 24'h0});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_frame0.push_back(24'h7E1357);
    exp_rd0.push_back(24'h000000);
    send0(4'h7, 4'hE, 16'h1357, acc);
    while (rdy0 !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (rdy0 !== 1'b1) $display("FAIL post_reset_frame_done got=%b required=1", rdy0);
    else pass_cnt++;
  endtask

  task automatic test_modes();
    logic [15:0] bitsA = 0, bitsB = 0, rdA = 0, rdB = 0;
    int edA = 0, edB = 0, rdcA = 0, rdcB = 0;
    logic pA, pB;
    chk_cnt++;
    if ({sclkA, sclkB} !== 2'b00) $display("FAIL modes_idle_sclk got=%b required=00", {sclkA, sclkB});
    else pass_cnt++;
    mcomm = 4'hC; maddr = 4'h3; mdata = 8'h81; mv = 1'b1;
    @(negedge clk);
    mv = 1'b0; mcomm = 4'h0; maddr = 4'h0; mdata = 8'h00;
    pA = 1'b0; pB = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (syncA === 1'b0) begin
        if (!pA && sclkA) edA++;
        if (pA && !sclkA) bitsA = {bitsA[14:0], mosiA};
      end
      if (syncB === 1'b0) begin
        if (!pB && sclkB) begin
          edB++;
          bitsB = {bitsB[14:0], mosiB};
        end
      end
      if (rdvA === 1'b1) begin rdcA++; rdA = rddA; end
      if (rdvB === 1'b1) begin rdcB++; rdB = rddB; end
      pA = sclkA; pB = sclkB;
      if (rdyA === 1'b1 && rdyB === 1'b1) break;
      @(negedge clk);
    end
    chk_cnt++;
    if ({edA, edB} !== {32'd16, 32'd16}) $display("FAIL modes_leading_edges got=%0d,%0d required=16,16", edA, edB);
    else pass_cnt++;
    chk_cnt++;
    if (bitsA !== 16'hC381) $display("FAIL mode_cpha1_bits got=%h required=c381", bitsA);
    else pass_cnt++;
    chk_cnt++;
    if (bitsB !== 16'hC381) $display("FAIL mode_cpha0_bits got=%h required=c381", bitsB);
    else pass_cnt++;
    chk_cnt++;
    if ({rdcA, rdcB} !== {32'd1, 32'd1} || rdA !== 16'hC381 || rdB !== 16'hC381)
      $display("FAIL modes_readback got=%0d:%h,%0d:%h required=1:c381,1:c381", rdcA, rdA, rdcB, rdB);
    else pass_cnt++;
    chk_cnt++;
    if ({sclkA, sclkB, rdyA, rdyB, errA, errB, busyA, busyB} !== 8'b00110000)
      $display("FAIL modes_end_state got=%b required=00110000", {sclkA, sclkB, rdyA, rdyB, errA, errB, busyA, busyB});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc1, rise_at = -1, fall2 = -1, gap = 0, bad1 = 0, bad2 = 0, ph = 0, n = 0;
    comm3 = 4'hA; addr3 = 4'h5; data3 = 16'h1111; cs3 = 2'd0; v3 = 1'b1;
    acc1 = cyc;
    @(negedge clk);
    comm3 = 4'h6; addr3 = 4'h9; data3 = 16'h2222; cs3 = 2'd2;
    for (int i = 0; i < 1000 && ph < 3; i++) begin
      if (rdy3 === 1'b1 && rise_at < 0) rise_at = cyc;
      if (ph == 0) begin
        if (sync3 === 3'b111) begin ph = 1; gap = 1; end
        else if (sync3 !== 3'b110) bad1++;
      end else if (ph == 1) begin
        if (sync3 === 3'b111) gap++;
        else begin
          ph = 2; fall2 = cyc; v3 = 1'b0;
          if (sync3 !== 3'b011) bad2++;
        end
      end else begin
        if (sync3 === 3'b111) ph = 3;
        else if (sync3 !== 3'b011) bad2++;
      end
      if (ph < 3) @(negedge clk);
    end
    v3 = 1'b0;
    while (rdy3 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (rise_at - acc1 != 209) $display("FAIL b2b_ready_latency got=%0d required=209", rise_at - acc1);
    else pass_cnt++;
    chk_cnt++;
    if (fall2 < 0 || fall2 != rise_at + 1) $display("FAIL b2b_second_accept got=%0d required=%0d", fall2, rise_at + 1);
    else pass_cnt++;
    chk_cnt++;
    if (gap < 8) $display("FAIL b2b_gap got=%0d required>=8", gap);
    else pass_cnt++;
    chk_cnt++;
    if (bad1 != 0 || bad2 != 0 || ph != 3) $display("FAIL b2b_chip_select got=%0d/%0d/%0d required=0/0/3", bad1, bad2, ph);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    int errs = 0, act = 0;
    cs3 = 2'd3; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0; cs3 = 2'd0;
    for (int i = 0; i < 20; i++) begin
      if (err3 === 1'b1) errs++;
      if (sync3 !== 3'b111 || busy3 !== 1'b0) act++;
      @(negedge clk);
    end
    chk_cnt++;
    if (errs != 1) $display("FAIL err_pulses got=%0d required=1", errs);
    else pass_cnt++;
    chk_cnt++;
    if (act != 0) $display("FAIL err_no_activity got=%0d required=0", act);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int edges = 0, n = 0, rdc = 0, t0;
    logic p;
    comm3 = 4'h9; addr3 = 4'h9; data3 = 16'hBEEF; cs3 = 2'd1; ab3 = 1'b1; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0; ab3 = 1'b0;
    chk_cnt++;
    if (sync3 !== 3'b101) $display("FAIL abort_idle_accept got=%b required=101", sync3);
    else pass_cnt++;
    p = sclk3;
    while (edges < 10 && n < 500) begin
      @(negedge clk);
      n++;
      if (rdv3 === 1'b1) rdc++;
      if (sclk3 !== p) edges++;
      p = sclk3;
    end
    ab3 = 1'b1;
    @(negedge clk);
    ab3 = 1'b0;
    chk_cnt++;
    if ({sync3, sclk3, mosi3} !== 5'b11110) $display("FAIL abort_outputs got=%b required=11110", {sync3, sclk3, mosi3});
    else pass_cnt++;
    t0 = cyc;
    n = 0;
    while (rdy3 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (rdv3 === 1'b1) rdc++;
    end
    chk_cnt++;
    if (cyc - t0 != 8) $display("FAIL abort_ready_latency got=%0d required=8", cyc - t0);
    else pass_cnt++;
    chk_cnt++;
    if (rdc != 0) $display("FAIL abort_rd_valid got=%0d required=0", rdc);
    else pass_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_readback();
    test_reset_mid_shift();
    test_modes();
    test_back_to_back();
    test_errors();
    test_abort();
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (exp_frame0.size() != 0) $display("FAIL frame0_missing got=%0d required=0", exp_frame0.size());
    else pass_cnt++;
    chk_cnt++;
    if (exp_rd0.size() != 0) $display("FAIL rd0_missing got=%0d required=0", exp_rd0.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
